ff_delay_line: RTL and testbench
================================

Name: ff_delay_line

Overview:
Parametrised, enable-gated delay line for WIDTH-bit data with a per-stage valid bit. The delay is runtime-selectable from 0 to MAX_DEPTH cycles of enable, and the line flushes on request or on a delay change. A fill counter reports when the output is backed by a complete history. It is used for aligning data/control paths across pipelines and as a generic stage-count-programmable retimer.

Parameters:
WIDTH, 8, data bits per stage (>=1)
MAX_DEPTH, 8, maximum number of register stages (>=1)
DW, $clog2(MAX_DEPTH+1), width of delay/count fields (localparam, not overridable)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, synchronous, active-low
en_i  in  1  advance the line by one stage when high
d_i  in  WIDTH  input data
d_valid_i  in  1  input valid, travels with d_i
delay_i  in  DW  requested delay in enabled cycles; 0..MAX_DEPTH
flush_i  in  1  clear all stage valid bits and the fill counter
q_o  out  WIDTH  delayed data
q_valid_o  out  1  valid bit aligned with q_o
full_o  out  1  fill counter == active delay (output history complete)
delay_err_o  out  1  delay_i > MAX_DEPTH, sampled value

Behaviour:
- Reset (rst_ni==0 at a clk edge): all stage data and valid bits = 0; fill_cnt = 0; delay_q = 0; delay_err_o = 0. q_o and q_valid_o then follow the delay 0 rule below.
- delay_q register: holds the active delay. Each cycle delay_i is compared with delay_q.
  - If delay_i > MAX_DEPTH: delay_err_o = 1 next cycle; delay_q unchanged; no flush.
  - Else if delay_i != delay_q: next cycle delay_q = delay_i, delay_err_o = 0, and an implicit flush occurs.
  - Else delay_err_o = 0.
- Shift: when en_i == 1 and no flush (explicit or implicit) that cycle: stage[0] <= {d_valid_i, d_i}; stage[k] <= stage[k-1]. Data stages shift regardless of valid; d_i is captured even when d_valid_i == 0.
- Flush (flush_i == 1 or implicit): all valid bits = 0 and fill_cnt = 0 next cycle. Data bits are left unchanged. Flush has priority over en_i; the input beat presented that cycle is dropped.
- Output tap:
  - delay_q == 0: q_o = d_i and q_valid_o = d_valid_i & en_i (combinational bypass).
  - Otherwise: q_o = stage[delay_q-1].data and q_valid_o = stage[delay_q-1].valid (registered, no comb path from d_i).
- Latency: a beat accepted with en_i high appears on the output after exactly delay_q further enabled edges. Cycles with en_i low are stalls and do not count.
- Fill counter (states EMPTY/FILLING/FULL, encoded by fill_cnt):
  - Increments on each non-flushed en_i cycle while fill_cnt < delay_q, saturating at delay_q.
  - full_o = (fill_cnt == delay_q). With delay_q == 0, full_o = 1 except in a cycle where a flush is pending.
- Simultaneous events: reset beats flush, flush beats shift. A delay change and flush_i in the same cycle give a single flush plus the delay update.
- Stall with en_i low: all state holds, including fill_cnt.
- Reset mid-stream: in-flight valid beats are discarded and no stale valid appears afterwards.
- No wrap-around: fill_cnt saturates and never exceeds MAX_DEPTH.

Decomposition:
- No package type is required. DW is derived locally. If the team's common package already provides a shared clog2-style width helper, use that rather than a local copy.
- Natural sub-module: ff_delay_stage, one WIDTH+1-bit register with enable and valid-clear. It is instantiated MAX_DEPTH times via generate, with the tap mux and fill counter in the top level.

Test Plan:
- Reset/idle: rst_ni low for 2 cycles with en_i=1, d_valid_i=1 -> q_valid_o=0, full_o=1 (delay_q=0), delay_err_o=0; then rst_ni high, d_i=0x5A -> q_o=0x5A, q_valid_o=1 in the same cycle.
- Fixed delay: delay_i=3, then 6 continuous valid beats 0x01..0x06 -> first cycle shows a flush, q_valid_o rises on the 3rd enabled edge after 0x01 with q_o=0x01, then 0x02..0x06 back to back; full_o high from that edge.
- Stall: delay 3, en_i low for 4 cycles mid-stream -> q_o/q_valid_o/fill_cnt frozen; resumes in order with no loss or duplication.
- Delay change: streaming at delay 4, switch delay_i to 2 -> all valids cleared, full_o=0 for 2 enabled cycles; new data appears after 2 edges; no pre-change beat appears.
- Flush vs enable: flush_i=1 with en_i=1 and d_i=0xAA valid -> 0xAA never reaches q_o; q_valid_o=0 until MAX_DEPTH fresh beats at delay MAX_DEPTH.
- Error/boundary: delay_i=MAX_DEPTH+1 (when representable) -> delay_err_o=1, delay_q unchanged, stream unaffected; delay_i=MAX_DEPTH -> latency exactly MAX_DEPTH, full_o after MAX_DEPTH enabled beats.

Source files
------------

// File: rtl/ff_delay_line_pkg.sv
// rtl/ff_delay_line_pkg.sv - shared width helper for the delay line
package ff_delay_line_pkg;

  // Bits needed to hold a delay/count value in 0..max_depth inclusive.
  function automatic int delay_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

endpackage

// File: rtl/ff_delay_stage.sv
// rtl/ff_delay_stage.sv - one data+valid register of the delay line
module ff_delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             d_valid_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Clear only drops the valid bit; the data payload is left in place.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clr_i) begin
      r_valid <= 1'b0;
    end else if (en_i) begin
      r_data  <= d_i;
      r_valid <= d_valid_i;
    end
  end

  assign q_o       = r_data;
  assign q_valid_o = r_valid;

endmodule

// File: rtl/ff_delay_line.sv
// rtl/ff_delay_line.sv - enable-gated, runtime-programmable delay line with fill tracking
module ff_delay_line
  import ff_delay_line_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_DEPTH = 8,
  localparam int DW        = delay_w(MAX_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             d_valid_i,
  input  logic [DW-1:0]    delay_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             full_o,
  output logic             delay_err_o
);

  logic [DW-1:0]    r_delay_q;
  logic [DW-1:0]    r_fill_cnt;
  logic             r_delay_err;

  logic             w_err;
  logic             w_chg;
  logic             w_flush;
  logic             w_shift;
  logic             w_bypass;
  logic [WIDTH-1:0] w_tap_data;
  logic             w_tap_valid;

  // Index 0 is the line input; index k is the output of stage k-1.
  logic [WIDTH-1:0] w_data  [0:MAX_DEPTH];
  logic             w_valid [0:MAX_DEPTH];

  assign w_err   = (delay_i > DW'(MAX_DEPTH));
  assign w_chg   = ~w_err & (delay_i != r_delay_q);
  assign w_flush = flush_i | w_chg;
  assign w_shift = en_i & ~w_flush;

  assign w_data[0]  = d_i;
  assign w_valid[0] = d_valid_i;

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    ff_delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (w_shift),
      .clr_i    (w_flush),
      .d_i      (w_data[k]),
      .d_valid_i(w_valid[k]),
      .q_o      (w_data[k+1]),
      .q_valid_o(w_valid[k+1])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_delay_q   <= '0;
      r_delay_err <= 1'b0;
    end else begin
      r_delay_err <= w_err;
      if (w_chg) begin
        r_delay_q <= delay_i;
      end
    end
  end

  // Saturates at the active delay, so it never exceeds MAX_DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fill_cnt <= '0;
    end else if (w_flush) begin
      r_fill_cnt <= '0;
    end else if (en_i && (r_fill_cnt < r_delay_q)) begin
      r_fill_cnt <= r_fill_cnt + DW'(1);
    end
  end

  always_comb begin
    w_tap_data  = '0;
    w_tap_valid = 1'b0;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (r_delay_q == DW'(k)) begin
        w_tap_data  = w_data[k];
        w_tap_valid = w_valid[k];
      end
    end
  end

  // Zero delay is a pure combinational bypass; valid is masked while in reset.
  assign w_bypass    = (r_delay_q == '0);
  assign q_o         = w_bypass ? d_i : w_tap_data;
  assign q_valid_o   = w_bypass ? (d_valid_i & en_i & rst_ni) : w_tap_valid;
  assign full_o      = (r_fill_cnt == r_delay_q) & ~(w_bypass & w_flush);
  assign delay_err_o = r_delay_err;

endmodule

// File: tb/tb_ff_delay_line.sv
// tb/tb_ff_delay_line.sv - directed self-checking bench for ff_delay_line
module tb_ff_delay_line;

  localparam int W  = 8;
  localparam int MD = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  d;
  logic          dv;
  logic [DW-1:0] delay;
  logic          flush;
  logic [W-1:0]  q;
  logic          qv;
  logic          full;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int g_e      = 0;

  always #5 clk = ~clk;

  ff_delay_line #(.WIDTH(W), .MAX_DEPTH(MD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .d_i(d), .d_valid_i(dv),
    .delay_i(delay), .flush_i(flush), .q_o(q), .q_valid_o(qv),
    .full_o(full), .delay_err_o(err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; dv = 1'b1; d = 8'h33; delay = '0; flush = 1'b0;
    cyc(); cyc();
    n_checks++; if (qv !== 1'b0) begin n_fail++; $display("FAIL reset_qv got=%b exp=0", qv); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL reset_full got=%b exp=1", full); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1; d = 8'h5A; #1;
    n_checks++; if (q !== 8'h5A || qv !== 1'b1) begin n_fail++; $display("FAIL reset_bypass got=%h/%b exp=5a/1", q, qv); end
  endtask

  task automatic test_fixed_delay();
    logic [W-1:0] eq;
    logic ev;
    int idx;
    en = 1'b0; dv = 1'b0; delay = 4'd3; cyc();
    n_checks++; if (full !== 1'b0 || qv !== 1'b0) begin n_fail++; $display("FAIL fixed_flush got full=%b qv=%b exp=0/0", full, qv); end
    for (int c = 0; c < 10; c++) begin
      en = 1'b1; dv = (c < 6); d = (c < 6) ? 8'(c + 1) : 8'(8'hF0 + c);
      cyc();
      idx = c - 1; ev = (idx >= 1 && idx <= 6); eq = 8'(idx);
      n_checks++; if (qv !== ev || (ev && q !== eq)) begin n_fail++; $display("FAIL fixed_q c=%0d got=%h/%b exp=%h/%b", c, q, qv, eq, ev); end
      n_checks++; if (full !== (c >= 2)) begin n_fail++; $display("FAIL fixed_full c=%0d got=%b exp=%b", c, full, (c >= 2)); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] eq;
    logic ev, stall;
    int e, idx;
    flush = 1'b1; en = 1'b1; d = 8'hAA; dv = 1'b1; cyc();
    flush = 1'b0;
    n_checks++; if (qv !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL stall_flush got qv=%b full=%b exp=0/0", qv, full); end
    e = 0;
    for (int i = 0; i < 14; i++) begin
      stall = (i >= 2 && i < 6);
      en = ~stall;
      if (stall) begin d = 8'hEE; dv = 1'b1; end
      else begin d = 8'(8'h10 + e); dv = (e < 6); end
      cyc();
      if (!stall) e++;
      idx = e - 3; ev = (idx >= 0 && idx < 6); eq = 8'(8'h10 + idx);
      n_checks++; if (qv !== ev || (ev && q !== eq)) begin n_fail++; $display("FAIL stall_q i=%0d got=%h/%b exp=%h/%b", i, q, qv, eq, ev); end
      n_checks++; if (full !== (e >= 3)) begin n_fail++; $display("FAIL stall_full i=%0d got=%b exp=%b", i, full, (e >= 3)); end
    end
  endtask

  task automatic test_delay_change();
    logic [W-1:0] eq;
    logic ev;
    int idx;
    en = 1'b0; delay = 4'd4; cyc();
    for (int c = 0; c < 6; c++) begin
      en = 1'b1; dv = 1'b1; d = 8'(8'h20 + c); cyc();
      idx = c - 3; ev = (idx >= 0); eq = 8'(8'h20 + idx);
      n_checks++; if (qv !== ev || (ev && q !== eq)) begin n_fail++; $display("FAIL d4_q c=%0d got=%h/%b exp=%h/%b", c, q, qv, eq, ev); end
    end
    delay = 4'd2; d = 8'h30; cyc();
    n_checks++; if (qv !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL chg_flush got qv=%b full=%b exp=0/0", qv, full); end
    for (int e = 1; e <= 4; e++) begin
      d = 8'(8'h40 + e - 1); cyc();
      idx = e - 2; ev = (idx >= 0); eq = 8'(8'h40 + idx);
      n_checks++; if (qv !== ev || (ev && q !== eq)) begin n_fail++; $display("FAIL d2_q e=%0d got=%h/%b exp=%h/%b", e, q, qv, eq, ev); end
      n_checks++; if (full !== (e >= 2)) begin n_fail++; $display("FAIL d2_full e=%0d got=%b exp=%b", e, full, (e >= 2)); end
    end
  endtask

  task automatic test_flush_vs_enable();
    logic [W-1:0] eq;
    logic ev;
    en = 1'b0; delay = 4'(MD); cyc();
    for (int c = 0; c < 3; c++) begin
      en = 1'b1; dv = 1'b1; d = 8'(8'h50 + c); cyc();
    end
    flush = 1'b1; d = 8'hAA; cyc();
    flush = 1'b0;
    n_checks++; if (qv !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL fl_flush got qv=%b full=%b exp=0/0", qv, full); end
    for (int e = 1; e <= 12; e++) begin
      d = 8'(8'h60 + e - 1); cyc();
      ev = (e >= MD); eq = 8'(8'h60 + e - MD);
      n_checks++; if (qv !== ev || (ev && q !== eq)) begin n_fail++; $display("FAIL fl_q e=%0d got=%h/%b exp=%h/%b", e, q, qv, eq, ev); end
      n_checks++; if (full !== ev) begin n_fail++; $display("FAIL fl_full e=%0d got=%b exp=%b", e, full, ev); end
    end
    g_e = 12;
  endtask

  task automatic test_delay_err();
    logic [W-1:0] eq;
    int e;
    e = g_e;
    for (int j = 0; j < 4; j++) begin
      delay = (j == 0) ? 4'(MD + 1) : 4'(MD);
      d = 8'(8'h60 + e); cyc();
      e++;
      eq = 8'(8'h60 + e - MD);
      n_checks++; if (err !== (j == 0)) begin n_fail++; $display("FAIL err_flag j=%0d got=%b exp=%b", j, err, (j == 0)); end
      n_checks++; if (qv !== 1'b1 || q !== eq || full !== 1'b1) begin n_fail++; $display("FAIL err_stream j=%0d got=%h/%b/%b exp=%h/1/1", j, q, qv, full, eq); end
    end
  endtask

  task automatic test_delay_zero();
    en = 1'b0; delay = '0; cyc();
    en = 1'b1; dv = 1'b1; d = 8'h77; #1;
    n_checks++; if (q !== 8'h77 || qv !== 1'b1 || full !== 1'b1) begin n_fail++; $display("FAIL zero_bypass got=%h/%b/%b exp=77/1/1", q, qv, full); end
    flush = 1'b1; #1;
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL zero_full_flush got=%b exp=0", full); end
    flush = 1'b0; #1;
  endtask

  task automatic test_reset_midstream();
    delay = 4'd2; en = 1'b1; dv = 1'b1; d = 8'h80; cyc();
    d = 8'h81; cyc();
    d = 8'h82; cyc();
    n_checks++; if (q !== 8'h81 || qv !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%h/%b exp=81/1", q, qv); end
    rst_n = 1'b0; d = 8'h83; cyc();
    n_checks++; if (qv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_qv got=%b exp=0", qv); end
    rst_n = 1'b1; dv = 1'b0; cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (qv !== 1'b0) begin n_fail++; $display("FAIL mid_stale i=%0d got=%b exp=0", i, qv); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_delay();
    test_stall();
    test_delay_change();
    test_flush_vs_enable();
    test_delay_err();
    test_delay_zero();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
